// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter: width codes, FSM states, requester IDs.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    W_BYTE = 2'b00,
    W_HALF = 2'b01,
    W_WORD = 2'b10,
    W_ILL  = 2'b11
  } width_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_e;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } src_e;

  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane handling for the data port: store enables/replication, misalignment
// detection, and load shift with zero/sign extension.
module mem_lane_align
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0]  st_off_i,
  input  width_e      st_width_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  output logic        misalign_o,
  input  logic [1:0]  ld_off_i,
  input  width_e      ld_width_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] ld_raw_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] shifted_s;

  // Store lane enables, replicated write data and legality of the access.
  always_comb begin
    st_be_o    = 4'b0000;
    st_wdata_o = 32'h0000_0000;
    misalign_o = 1'b0;
    case (st_width_i)
      W_BYTE: begin
        st_be_o    = 4'b0001 << st_off_i;
        st_wdata_o = {4{st_wdata_i[7:0]}};
      end
      W_HALF: begin
        st_be_o    = 4'b0011 << st_off_i;
        st_wdata_o = {2{st_wdata_i[15:0]}};
        misalign_o = st_off_i[0];
      end
      W_WORD: begin
        st_be_o    = 4'b1111;
        st_wdata_o = st_wdata_i;
        misalign_o = |st_off_i;
      end
      default: misalign_o = 1'b1;
    endcase
  end

  // Load data: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted_s = ld_raw_i >> {ld_off_i, 3'b000};
    case (ld_width_i)
      W_BYTE:  ld_data_o = {{24{~ld_unsigned_i & shifted_s[7]}}, shifted_s[7:0]};
      W_HALF:  ld_data_o = {{16{~ld_unsigned_i & shifted_s[15]}}, shifted_s[15:0]};
      default: ld_data_o = shifted_s;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding memory port shared by fetch (I) and data (D); D has priority,
// a starvation counter forces an I grant after STARVE_MAX consecutive D grants.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_width,
  input  logic        d_unsigned,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [3:0]  m_be,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata
);

  state_e      state_q, state_d;
  src_e        src_q;
  logic        we_q, err_q, uns_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  width_e      width_q;
  logic [1:0]  off_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        load_s, pick_i_s, misalign_s;
  logic [3:0]  st_be_s;
  logic [31:0] st_wdata_s, ld_data_s;

  mem_lane_align u_align (
    .st_off_i      (d_addr[1:0]),
    .st_width_i    (width_e'(d_width)),
    .st_wdata_i    (d_wdata),
    .st_be_o       (st_be_s),
    .st_wdata_o    (st_wdata_s),
    .misalign_o    (misalign_s),
    .ld_off_i      (off_q),
    .ld_width_i    (width_q),
    .ld_unsigned_i (uns_q),
    .ld_raw_i      (m_rdata),
    .ld_data_o     (ld_data_s)
  );

  // State register and starvation counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; a rejected D request returns to IDLE so its still-high d_req is not re-sampled.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_req || d_req) state_d = ISSUE; else state_d = IDLE;
      ISSUE:   if (err_q) state_d = IDLE; else state_d = WAIT;
      WAIT:    if (m_ack) state_d = RESP; else state_d = WAIT;
      RESP:    if (i_req || d_req) state_d = ISSUE; else state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign load_s   = (state_d == ISSUE);
  assign pick_i_s = i_req && (!d_req || (cnt_q == CNT_W'(STARVE_MAX)));

  // Starvation counter update at each selection.
  always_comb begin
    cnt_d = cnt_q;
    if (load_s && pick_i_s) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (load_s && i_req) begin
      if (cnt_q == CNT_W'(STARVE_MAX)) cnt_d = cnt_q;
      else cnt_d = cnt_q + CNT_W'(1);
    end else if ((state_q == IDLE) && !i_req) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Command latch at selection, and response capture at the m_ack edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_q   <= SRC_I;
      we_q    <= 1'b0;
      addr_q  <= 32'h0000_0000;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0000_0000;
      err_q   <= 1'b0;
      width_q <= W_BYTE;
      uns_q   <= 1'b0;
      off_q   <= 2'b00;
      rdata_q <= 32'h0000_0000;
    end else begin
      if (load_s) begin
        if (pick_i_s) begin
          src_q   <= SRC_I;
          we_q    <= 1'b0;
          addr_q  <= word_addr(i_addr);
          be_q    <= 4'b1111;
          wdata_q <= 32'h0000_0000;
          err_q   <= 1'b0;
          width_q <= W_WORD;
          uns_q   <= 1'b0;
          off_q   <= 2'b00;
        end else begin
          src_q   <= SRC_D;
          we_q    <= d_we;
          addr_q  <= word_addr(d_addr);
          be_q    <= d_we ? st_be_s : 4'b1111;
          wdata_q <= d_we ? st_wdata_s : 32'h0000_0000;
          err_q   <= misalign_s;
          width_q <= width_e'(d_width);
          uns_q   <= d_unsigned;
          off_q   <= d_addr[1:0];
        end
      end
      if ((state_q == WAIT) && m_ack) begin
        if (src_q == SRC_I) rdata_q <= m_rdata;
        else if (we_q) rdata_q <= 32'h0000_0000;
        else rdata_q <= ld_data_s;
      end
    end
  end

  // Outputs decode only registered state, so reset clears them immediately.
  always_comb begin
    i_gnt    = 1'b0;
    i_rvalid = 1'b0;
    i_rdata  = 32'h0000_0000;
    d_gnt    = 1'b0;
    d_rvalid = 1'b0;
    d_rdata  = 32'h0000_0000;
    d_err    = 1'b0;
    m_req    = 1'b0;
    m_we     = 1'b0;
    m_addr   = 32'h0000_0000;
    m_be     = 4'b0000;
    m_wdata  = 32'h0000_0000;
    case (state_q)
      ISSUE: begin
        if (err_q) begin
          d_gnt = 1'b1;
          d_err = 1'b1;
        end else begin
          m_req   = 1'b1;
          m_we    = we_q;
          m_addr  = addr_q;
          m_be    = be_q;
          m_wdata = wdata_q;
          i_gnt   = (src_q == SRC_I);
          d_gnt   = (src_q == SRC_D);
        end
      end
      WAIT: begin
        m_we    = we_q;
        m_addr  = addr_q;
        m_be    = be_q;
        m_wdata = wdata_q;
      end
      RESP: begin
        if (src_q == SRC_I) begin
          i_rvalid = 1'b1;
          i_rdata  = rdata_q;
        end else begin
          d_rvalid = 1'b1;
          d_rdata  = rdata_q;
        end
      end
      default: begin
        m_req = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed steps push expected grants,
// memory commands and responses; monitor and memory responder pop and compare.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_unsigned, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [1:0]  d_width;
  logic        m_req, m_we, m_ack;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_width(d_width), .d_unsigned(d_unsigned),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit src_d; bit err; } gnt_t;
  typedef struct { bit we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata;
                   logic [31:0] rd; int lat; bit abandon; } cmd_t;
  typedef struct { bit src_d; logic [31:0] data; } rsp_t;

  gnt_t gnt_q[$];
  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  gnt_t mg;
  rsp_t mr;
  cmd_t rc;

  int n_cmp = 0;
  int n_err = 0;
  int i_gnt_cyc = 0, d_rv_cyc = 0, i_rv_cyc = 0;
  int t0, ng;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input bit we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input logic [31:0] rd, input int lat,
                          input bit abandon);
    cmd_t c;
    c.we = we; c.addr = addr; c.be = be; c.wdata = wdata; c.rd = rd; c.lat = lat;
    c.abandon = abandon;
    cmd_q.push_back(c);
  endtask

  task automatic push_gnt(input bit src_d, input bit err);
    gnt_t g;
    g.src_d = src_d; g.err = err;
    gnt_q.push_back(g);
  endtask

  task automatic push_rsp(input bit src_d, input logic [31:0] data);
    rsp_t r;
    r.src_d = src_d; r.data = data;
    rsp_q.push_back(r);
  endtask

  task automatic exp_i(input logic [31:0] waddr, input logic [31:0] rd, input int lat);
    push_gnt(1'b0, 1'b0);
    push_cmd(1'b0, waddr, 4'hF, 32'h0, rd, lat, 1'b0);
    push_rsp(1'b0, rd);
  endtask

  task automatic exp_d(input bit we, input logic [31:0] waddr, input logic [3:0] be,
                       input logic [31:0] wdata, input logic [31:0] rd, input int lat,
                       input logic [31:0] rsp);
    push_gnt(1'b1, 1'b0);
    push_cmd(we, waddr, be, wdata, rd, lat, 1'b0);
    push_rsp(1'b1, rsp);
  endtask

  task automatic drv_d(input bit we, input logic [31:0] a, input logic [1:0] w, input bit u,
                       input logic [31:0] wd);
    d_req = 1'b1; d_we = we; d_addr = a; d_width = w; d_unsigned = u; d_wdata = wd;
  endtask

  task automatic wait_gnts();
    for (int k = 0; k < 100 && (i_req || d_req); k++) begin
      @(negedge clk);
      if (d_gnt) d_req = 1'b0;
      if (i_gnt) i_req = 1'b0;
    end
    chk("gnt_wait", 32'({i_req, d_req}), 32'h0);
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && (gnt_q.size() + cmd_q.size() + rsp_q.size()) != 0; k++)
      @(negedge clk);
    chk("drain", 32'(gnt_q.size() + cmd_q.size() + rsp_q.size()), 32'h0);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_d(input bit we, input logic [31:0] a, input logic [1:0] w, input bit u,
                      input logic [31:0] wd, input logic [3:0] be, input logic [31:0] mwd,
                      input logic [31:0] rd, input logic [31:0] rsp);
    exp_d(we, {a[31:2], 2'b00}, be, mwd, rd, 1, rsp);
    drv_d(we, a, w, u, wd);
    t0 = cyc;
    wait_gnts();
    drain();
  endtask

  task automatic do_derr(input bit we, input logic [31:0] a, input logic [1:0] w);
    push_gnt(1'b1, 1'b1);
    drv_d(we, a, w, 1'b0, 32'h5A5A5A5A);
    wait_gnts();
    drain();
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctrl"}, 32'({i_gnt, i_rvalid, d_gnt, d_rvalid, d_err, m_req, m_we, m_be}), 32'h0);
    chk({tag, "_data"}, i_rdata | d_rdata | m_addr | m_wdata, 32'h0);
  endtask

  // Memory responder: checks each command, acks after its latency.
  initial begin
    m_ack = 1'b0;
    m_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (m_req === 1'b1) begin
        chk("cmd_expected", (cmd_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
        if (cmd_q.size() != 0) rc = cmd_q.pop_front();
        else begin
          rc.we = 1'b0; rc.addr = 32'h0; rc.be = 4'h0; rc.wdata = 32'h0;
          rc.rd = 32'h0; rc.lat = 1; rc.abandon = 1'b1;
        end
        chk("m_we", 32'(m_we), 32'(rc.we));
        chk("m_addr", m_addr, rc.addr);
        chk("m_be", 32'(m_be), 32'(rc.be));
        chk("m_wdata", m_wdata, rc.wdata);
        for (int k = 0; k < rc.lat; k++) begin
          @(posedge clk);
          #1;
        end
        m_ack = 1'b1;
        m_rdata = rc.rd;
        @(negedge clk);
        if (!rc.abandon) begin
          chk("m_hold_addr", m_addr, rc.addr);
          chk("m_req_pulse", 32'(m_req), 32'h0);
        end
        @(posedge clk);
        #1;
        m_ack = 1'b0;
        m_rdata = 32'h0;
      end
    end
  end

  // Grant/response monitor against the scoreboard queues.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (i_gnt || d_gnt) begin
          chk("gnt_expected", (gnt_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
          if (gnt_q.size() != 0) begin
            mg = gnt_q.pop_front();
            chk("gnt_d", 32'(d_gnt), 32'(mg.src_d));
            chk("gnt_i", 32'(i_gnt), 32'(!mg.src_d));
            chk("gnt_err", 32'(d_err), 32'(mg.err));
          end
          if (i_gnt) i_gnt_cyc = cyc;
        end else if (d_err) begin
          chk("err_without_gnt", 32'(d_err), 32'h0);
        end
        if (i_rvalid || d_rvalid) begin
          chk("rsp_expected", (rsp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
          if (rsp_q.size() != 0) begin
            mr = rsp_q.pop_front();
            chk("rsp_d", 32'(d_rvalid), 32'(mr.src_d));
            chk("rsp_i", 32'(i_rvalid), 32'(!mr.src_d));
            chk("rsp_data", mr.src_d ? d_rdata : i_rdata, mr.data);
          end
          if (d_rvalid) d_rv_cyc = cyc;
          if (i_rvalid) i_rv_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_width = 2'b00; d_unsigned = 1'b0;
    d_wdata = 32'h0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    rst = 1'b1;
    @(negedge clk);

    // I only, ack two cycles after m_req
    exp_i(32'h00400004, 32'h00A00093, 2);
    i_req = 1'b1; i_addr = 32'h00400004;
    t0 = cyc;
    wait_gnts();
    drain();
    chk("t1_latency", 32'(i_rv_cyc - t0), 32'd4);

    // simultaneous I and D: D first, I issued right after D's RESP
    exp_d(1'b0, 32'h10010000, 4'hF, 32'h0, 32'h11112222, 1, 32'h11112222);
    exp_i(32'h00400008, 32'h00B00113, 1);
    i_req = 1'b1; i_addr = 32'h00400008;
    drv_d(1'b0, 32'h10010000, 2'b10, 1'b0, 32'h0);
    wait_gnts();
    drain();
    chk("t2_i_after_d", 32'(i_gnt_cyc - d_rv_cyc), 32'd1);

    // both held continuously: D,D,D,D,I,D,D,D,D,I
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4) exp_i(32'h00400010, 32'hC0DE0000 + 32'(k), 1);
      else exp_d(1'b0, 32'h10010020, 4'hF, 32'h0, 32'hDA7A0000 + 32'(k), 1, 32'hDA7A0000 + 32'(k));
    end
    i_req = 1'b1; i_addr = 32'h00400010;
    drv_d(1'b0, 32'h10010020, 2'b10, 1'b0, 32'h0);
    ng = 0;
    for (int k = 0; k < 400 && ng < 10; k++) begin
      @(negedge clk);
      if (i_gnt || d_gnt) ng++;
    end
    i_req = 1'b0; d_req = 1'b0;
    chk("t3_grants", 32'(ng), 32'd10);
    drain();

    // store lanes and load extraction
    do_d(1'b1, 32'h10010003, 2'b00, 1'b0, 32'h000000AB, 4'b1000, 32'hABABABAB, 32'hDEADBEEF, 32'h0);
    do_d(1'b0, 32'h10010003, 2'b00, 1'b0, 32'h0, 4'hF, 32'h0, 32'hAB000000, 32'hFFFFFFAB);
    chk("t4_min_latency", 32'(d_rv_cyc - t0), 32'd3);
    do_d(1'b0, 32'h10010003, 2'b00, 1'b1, 32'h0, 4'hF, 32'h0, 32'hAB000000, 32'h000000AB);
    do_d(1'b1, 32'h10010002, 2'b01, 1'b0, 32'h00001234, 4'b1100, 32'h12341234, 32'h0, 32'h0);
    do_d(1'b1, 32'h10010000, 2'b10, 1'b0, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 32'h0, 32'h0);
    do_d(1'b0, 32'h10010002, 2'b01, 1'b0, 32'h0, 4'hF, 32'h0, 32'h80010000, 32'hFFFF8001);
    do_d(1'b0, 32'h10010002, 2'b01, 1'b1, 32'h0, 4'hF, 32'h0, 32'h80010000, 32'h00008001);
    do_d(1'b0, 32'h10010000, 2'b01, 1'b0, 32'h0, 4'hF, 32'h0, 32'h12347FFF, 32'h00007FFF);
    do_d(1'b0, 32'h10010001, 2'b00, 1'b0, 32'h0, 4'hF, 32'h0, 32'h0000FE00, 32'hFFFFFFFE);

    // illegal accesses, then a legal one
    do_derr(1'b0, 32'h10010002, 2'b10);
    do_derr(1'b0, 32'h10010001, 2'b01);
    do_derr(1'b0, 32'h10010000, 2'b11);
    do_derr(1'b1, 32'h10010001, 2'b10);
    do_d(1'b0, 32'h10010004, 2'b10, 1'b0, 32'h0, 4'hF, 32'h0, 32'h76543210, 32'h76543210);

    // reset mid-WAIT, stale ack afterwards, then a clean fetch
    push_gnt(1'b0, 1'b0);
    push_cmd(1'b0, 32'h00400020, 4'hF, 32'h0, 32'h55555555, 4, 1'b1);
    i_req = 1'b1; i_addr = 32'h00400020;
    wait_gnts();
    @(negedge clk);
    chk("t6_wait_addr", m_addr, 32'h00400020);
    rst = 1'b0;
    #1;
    chk_quiet("t6_async");
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk_quiet("t6_stale_ack");
    exp_i(32'h00400024, 32'h12345678, 1);
    i_req = 1'b1; i_addr = 32'h00400024;
    wait_gnts();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
